secure_scrub_fifo: RTL and testbench

Small buffering stage placed directly downstream of the secure data-capture register; it accepts captured words over a valid/ready handshake and holds them until the consumer drains them. Every storage slot is zeroized when its word is consumed, on reset, and on an explicit scrub request. No stale sensitive data remains in the buffer once it has been read or discarded.

---
 rtl/secure_scrub_fifo_pkg.sv | 13 +
 rtl/secure_scrub_fifo_if.sv | 30 +++
 rtl/secure_scrub_fifo.sv | 105 ++++++++++
 tb/tb_secure_scrub_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_scrub_fifo_pkg.sv
// Shared definitions for the secure scrubbing buffer: FSM state encoding and
// an all-zero word constant that users slice to their own width.
package secure_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_e;

  localparam int ZERO_W_MAX = 1024;
  localparam logic [ZERO_W_MAX-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/secure_scrub_fifo_if.sv
// Handshake, data and scrub-control bundle between a producer/consumer
// (master) and the scrubbing buffer (slave).
interface secure_scrub_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             scrub_req;
  logic             scrub_busy;
  logic             scrub_done;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready, scrub_req,
    input  in_ready, out_valid, out_data, scrub_busy, scrub_done, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, scrub_req,
    output in_ready, out_valid, out_data, scrub_busy, scrub_done, count
  );

endinterface

// File: rtl/secure_scrub_fifo.sv
// Small FIFO that zeroizes every slot when it is consumed, on reset and on a
// scrub request, so no stale captured data lingers in storage.
module secure_scrub_fifo
  import secure_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  secure_scrub_fifo_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    scrub_idx_q, scrub_idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pending scrub request blocks both sides combinationally in that cycle.
  assign bus.in_ready  = (state_q == IDLE) && !full  && !bus.scrub_req;
  assign bus.out_valid = (state_q == IDLE) && !empty && !bus.scrub_req;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign bus.out_data   = bus.out_valid ? mem_q[rd_ptr_q] : ZERO_WORD[WIDTH-1:0];
  assign bus.scrub_busy = (state_q == SCRUB);
  assign bus.scrub_done = done_q;
  assign bus.count      = count_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    scrub_idx_d = scrub_idx_q;
    count_d     = count_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.scrub_req) begin
          state_d     = SCRUB;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          scrub_idx_d = '0;
          count_d     = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + PW'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
          if (push && !pop)      count_d = count_q + CW'(1);
          else if (pop && !push) count_d = count_q - CW'(1);
        end
      end
      SCRUB: begin
        scrub_idx_d = scrub_idx_q + PW'(1);
        if (scrub_idx_q == PW'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      scrub_idx_q <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      scrub_idx_q <= scrub_idx_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

  // Three write sources: scrub sweep, push, and clear-on-pop (push/pop never share a slot).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ZERO_WORD[WIDTH-1:0];
    end else if (state_q == SCRUB) begin
      mem_q[scrub_idx_q] <= ZERO_WORD[WIDTH-1:0];
    end else begin
      if (push) mem_q[wr_ptr_q] <= bus.in_data;
      if (pop)  mem_q[rd_ptr_q] <= ZERO_WORD[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_secure_scrub_fifo.sv
// Self-checking bench for secure_scrub_fifo: directed scenarios plus a
// randomized push/pop run against a queue-based reference model.
module tb_secure_scrub_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  secure_scrub_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  secure_scrub_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.scrub_req = 1'b0;
  endtask

  function automatic int nonzero_entries();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.mem_q[i] !== '0) n++;
    return n;
  endfunction

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.scrub_busy !== 1'b0 || bus.scrub_done !== 1'b0) begin n_fail++; $display("FAIL reset_scrub_flags: got busy=%b done=%b want 0/0", bus.scrub_busy, bus.scrub_done); end
    n_checks++; if (nonzero_entries() != 0) begin n_fail++; $display("FAIL reset_mem: got %0d nonzero entries want 0", nonzero_entries()); end
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] words [3];
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h12345678;
    words[2] = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = words[i];
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      cycle();
    end
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.count !== 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_head: got v=%b %h want 1 deadbeef", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.out_data !== words[i]) begin n_fail++; $display("FAIL basic_pop[%0d]: got %h want %h", i, bus.out_data, words[i]); end
      cycle();
    end
    bus.out_ready = 1'b0;
    #1;
    n_checks++; if (bus.count !== 0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got count=%0d v=%b want 0/0", bus.count, bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL basic_out_zero: got %h want 0", bus.out_data); end
    n_checks++; if (nonzero_entries() != 0) begin n_fail++; $display("FAIL basic_mem_zero: got %0d nonzero want 0", nonzero_entries()); end
  endtask

  task automatic test_full_wrap();
    for (int v = 1; v <= DEPTH; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(v);
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b want 1", v, bus.in_ready); end
      cycle();
    end
    bus.in_data = 32'd9;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    cycle();
    n_checks++; if (bus.count !== 8) begin n_fail++; $display("FAIL full_no_ninth: got count=%0d want 8", bus.count); end
    // Full: the pop goes through, the offered push does not.
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.out_data !== 32'd1) begin n_fail++; $display("FAIL full_pop_head: got rdy=%b %h want 0 1", bus.in_ready, bus.out_data); end
    cycle();
    n_checks++; if (bus.count !== 7) begin n_fail++; $display("FAIL full_pop_count: got %0d want 7", bus.count); end
    #1;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_data !== 32'd2) begin n_fail++; $display("FAIL concurrent_pre: got rdy=%b %h want 1 2", bus.in_ready, bus.out_data); end
    cycle();
    n_checks++; if (bus.count !== 7) begin n_fail++; $display("FAIL concurrent_count: got %0d want 7", bus.count); end
    bus.in_valid = 1'b0;
    for (int v = 3; v <= 9; v++) begin
      #1;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== WIDTH'(v)) begin n_fail++; $display("FAIL wrap_order[%0d]: got v=%b %h want 1 %h", v, bus.out_valid, bus.out_data, v); end
      cycle();
    end
    bus.out_ready = 1'b0;
    #1;
    n_checks++; if (bus.count !== 0 || nonzero_entries() != 0) begin n_fail++; $display("FAIL wrap_drained: got count=%0d nonzero=%0d want 0/0", bus.count, nonzero_entries()); end
  endtask

  task automatic test_scrub();
    int busy_cycles;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom | 32'h1;
      cycle();
    end
    bus.scrub_req = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL scrub_block: got rdy=%b v=%b want 0/0", bus.in_ready, bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL scrub_out_zero: got %h want 0", bus.out_data); end
    cycle();
    idle_inputs();
    #1;
    n_checks++; if (bus.count !== 0) begin n_fail++; $display("FAIL scrub_count: got %0d want 0", bus.count); end
    busy_cycles = 0;
    while (bus.scrub_busy === 1'b1 && busy_cycles < 20) begin
      busy_cycles++;
      n_checks++; if (bus.scrub_done !== 1'b0 || bus.count !== 0) begin n_fail++; $display("FAIL scrub_during: got done=%b count=%0d want 0/0", bus.scrub_done, bus.count); end
      cycle();
    end
    n_checks++; if (busy_cycles != DEPTH) begin n_fail++; $display("FAIL scrub_busy_len: got %0d want %0d", busy_cycles, DEPTH); end
    n_checks++; if (bus.scrub_done !== 1'b1) begin n_fail++; $display("FAIL scrub_done_pulse: got %b want 1", bus.scrub_done); end
    cycle();
    n_checks++; if (bus.scrub_done !== 1'b0) begin n_fail++; $display("FAIL scrub_done_width: got %b want 0", bus.scrub_done); end
    n_checks++; if (nonzero_entries() != 0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL scrub_after: got nonzero=%0d rdy=%b want 0/1", nonzero_entries(), bus.in_ready); end
  endtask

  task automatic test_scrub_held();
    bit exp_busy;
    int waited;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA000_0000 + i;
      cycle();
    end
    bus.scrub_req = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL held_block[%0d]: got rdy=%b v=%b want 0/0", k, bus.in_ready, bus.out_valid); end
      cycle();
      exp_busy = (k != DEPTH + 1);
      n_checks++; if (bus.scrub_busy !== exp_busy || bus.count !== 0) begin n_fail++; $display("FAIL held_busy[%0d]: got busy=%b count=%0d want %b/0", k, bus.scrub_busy, bus.count, exp_busy); end
    end
    idle_inputs();
    waited = 0;
    while (bus.scrub_done !== 1'b1 && waited < 20) begin
      cycle();
      waited++;
    end
    n_checks++; if (bus.scrub_done !== 1'b1 || waited != 6) begin n_fail++; $display("FAIL held_second_done: got done=%b after %0d cycles want 1 after 6", bus.scrub_done, waited); end
    n_checks++; if (nonzero_entries() != 0) begin n_fail++; $display("FAIL held_mem_zero: got %0d nonzero want 0", nonzero_entries()); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hB000_0001 + i;
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.scrub_req = 1'b1;
    cycle();
    bus.scrub_req = 1'b0;
    repeat (3) cycle();
    n_checks++; if (bus.scrub_busy !== 1'b1 || nonzero_entries() != 3) begin n_fail++; $display("FAIL midscrub_state: got busy=%b nonzero=%0d want 1/3", bus.scrub_busy, nonzero_entries()); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.scrub_busy !== 1'b0 || bus.scrub_done !== 1'b0 || bus.count !== 0) begin n_fail++; $display("FAIL async_rst_ctrl: got busy=%b done=%b count=%0d want 0/0/0", bus.scrub_busy, bus.scrub_done, bus.count); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin n_fail++; $display("FAIL async_rst_io: got rdy=%b v=%b %h want 1/0/0", bus.in_ready, bus.out_valid, bus.out_data); end
    n_checks++; if (nonzero_entries() != 0) begin n_fail++; $display("FAIL async_rst_mem: got %0d nonzero want 0", nonzero_entries()); end
    #3;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5A5_0001;
    cycle();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.count !== 1 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL post_rst_push: got count=%0d v=%b %h want 1/1/a5a50001", bus.count, bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.count !== 0 || nonzero_entries() != 0) begin n_fail++; $display("FAIL post_rst_pop: got count=%0d nonzero=%0d want 0/0", bus.count, nonzero_entries()); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] model_q [$];
    int model_rd;
    do_reset();
    model_q.delete();
    model_rd = 0;
    for (int c = 0; c < 600; c++) begin
      int phase;
      int pslot;
      bit iv, ordy, exp_ir, exp_ov, push, pop;
      logic [WIDTH-1:0] d, exp_od;
      phase = (c / 100) % 3;
      if (phase == 0)      begin iv = ($urandom_range(0, 3) != 0); ordy = ($urandom_range(0, 3) == 0); end
      else if (phase == 1) begin iv = ($urandom_range(0, 3) == 0); ordy = ($urandom_range(0, 3) != 0); end
      else                 begin iv = 1'($urandom_range(0, 1));    ordy = 1'($urandom_range(0, 1));    end
      d = $urandom;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      exp_ir = (model_q.size() < DEPTH);
      exp_ov = (model_q.size() > 0);
      exp_od = exp_ov ? model_q[0] : '0;
      #1;
      n_checks++; if (bus.in_ready !== exp_ir || bus.out_valid !== exp_ov) begin n_fail++; $display("FAIL rand_hs[%0d]: got rdy=%b v=%b want %b/%b", c, bus.in_ready, bus.out_valid, exp_ir, exp_ov); end
      n_checks++; if (bus.out_data !== exp_od) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", c, bus.out_data, exp_od); end
      push = iv && exp_ir;
      pop  = ordy && exp_ov;
      cycle();
      pslot = model_rd;
      if (pop) begin
        void'(model_q.pop_front());
        model_rd = (model_rd + 1) % DEPTH;
      end
      if (push) model_q.push_back(d);
      n_checks++; if (bus.count !== model_q.size()) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, bus.count, model_q.size()); end
      if (pop) begin
        n_checks++; if (dut.mem_q[pslot] !== '0) begin n_fail++; $display("FAIL rand_slot_zero[%0d]: slot %0d got %h want 0", c, pslot, dut.mem_q[pslot]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_full_wrap();
    test_scrub();
    test_scrub_held();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
